// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiters: port indices, state mode and
// a one-hot decode helper.
package noc_arb_pkg;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

    localparam int ONEHOT_MAX = 64;

    typedef enum logic {
        ARB_OWN  = 1'b0,
        ARB_IDLE = 1'b1
    } arb_mode_e;

    // Callers size the result down to their own port count.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [ONEHOT_MAX-1:0] vec;
        vec = '0;
        if ((idx < n) && (idx < ONEHOT_MAX)) begin
            vec[idx] = 1'b1;
        end else begin
            vec = '0;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Cyclic first-one finder: returns the first set request at or after start,
// wrapping from NUM_PORTS-1 back to 0.
module rr_priority_pick
#(
    parameter int NUM_PORTS = 5
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] start,
    output logic                         found,
    output logic [$clog2(NUM_PORTS)-1:0] idx
);

    localparam int IW = $clog2(NUM_PORTS);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= NUM_PORTS) begin
                pos = pos - NUM_PORTS;
            end else begin
                pos = pos;
            end
            if (req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_param.sv
// Round-robin output-port arbiter with RTS/DCTS handshake toward the downstream
// router and an optional per-owner hold limit for fairness.
module arbiter_rr_param
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 5,
    parameter int IDLE_FIRST = PORT_L,
    parameter int HOLD_MAX   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         req,
    input  logic                         dcts,
    output logic                         rts,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [NUM_PORTS-1:0]         xbar_sel,
    output logic [$clog2(NUM_PORTS)-1:0] owner,
    output logic                         busy
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    typedef struct packed {
        arb_mode_e       mode;
        logic [IW-1:0]   idx;
    } arb_state_t;

    arb_state_t        state_r;
    logic              rts_r;
    logic [HW-1:0]     hold_cnt_r;

    arb_state_t        state_nxt_s;
    logic              idle_s;
    logic [NUM_PORTS-1:0] own_vec_s;
    logic              others_s;
    logic              hold_hit_s;
    logic [IW-1:0]     start_s;
    logic              found_s;
    logic [IW-1:0]     pick_idx_s;
    logic              handshake_s;
    logic              stall_s;
    logic              rts_nxt_s;
    logic [HW-1:0]     hold_nxt_s;

    // Owner decode and the start point of the cyclic search.
    always_comb begin
        idle_s      = (state_r.mode == ARB_IDLE);
        own_vec_s   = NUM_PORTS'(onehot(32'(state_r.idx), NUM_PORTS));
        others_s    = |(req & ~own_vec_s);
        handshake_s = rts_r & dcts;
        stall_s     = rts_r & ~dcts;
        hold_hit_s  = 1'b0;
        if ((HOLD_MAX > 0) && !idle_s && (hold_cnt_r >= HOLD_LIM) && others_s) begin
            hold_hit_s = 1'b1;
        end else begin
            hold_hit_s = 1'b0;
        end
        if (idle_s) begin
            start_s = IW'(IDLE_FIRST);
        end else if (hold_hit_s) begin
            // Start just past the owner so it is searched last.
            if (state_r.idx == IW'(NUM_PORTS - 1)) begin
                start_s = '0;
            end else begin
                start_s = state_r.idx + IW'(1);
            end
        end else begin
            start_s = state_r.idx;
        end
    end

    rr_priority_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .req  (req),
        .start(start_s),
        .found(found_s),
        .idx  (pick_idx_s)
    );

    // Next state, next rts and hold counter update.
    always_comb begin
        if (found_s) begin
            state_nxt_s = '{mode: ARB_OWN, idx: pick_idx_s};
        end else begin
            state_nxt_s = '{mode: ARB_IDLE, idx: '0};
        end

        if (idle_s) begin
            rts_nxt_s = 1'b0;
        end else if (handshake_s) begin
            rts_nxt_s = 1'b0;
        end else begin
            rts_nxt_s = 1'b1;
        end

        if (stall_s) begin
            hold_nxt_s = hold_cnt_r;
        end else if (state_nxt_s != state_r) begin
            hold_nxt_s = '0;
        end else if (handshake_s && (hold_cnt_r < HOLD_LIM)) begin
            hold_nxt_s = hold_cnt_r + HW'(1);
        end else begin
            hold_nxt_s = hold_cnt_r;
        end
    end

    // State registers; a stalled handshake freezes the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= '{mode: ARB_IDLE, idx: '0};
            rts_r      <= 1'b0;
            hold_cnt_r <= '0;
        end else begin
            if (!stall_s) begin
                state_r <= state_nxt_s;
            end else begin
                state_r <= state_r;
            end
            rts_r      <= rts_nxt_s;
            hold_cnt_r <= hold_nxt_s;
        end
    end

    // Output decode from state; grant additionally qualified by the live handshake.
    always_comb begin
        rts  = rts_r;
        busy = ~idle_s;
        if (idle_s) begin
            owner    = '0;
            xbar_sel = '0;
            grant    = '0;
        end else begin
            owner    = state_r.idx;
            xbar_sel = own_vec_s;
            if (handshake_s) begin
                grant = own_vec_s;
            end else begin
                grant = '0;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Directed bench for arbiter_rr_param: default 5-port, 5-port with hold limit 2,
// and an 8-port build, each with hand-computed expectations.
module tb_arbiter_rr_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [4:0] a_req = '0, b_req = '0;
    logic [7:0] c_req = '0;
    logic       a_dcts = 1'b0, b_dcts = 1'b0, c_dcts = 1'b0;

    logic       a_rts, b_rts, c_rts, a_busy, b_busy, c_busy;
    logic [4:0] a_grant, a_xbar, b_grant, b_xbar;
    logic [7:0] c_grant, c_xbar;
    logic [2:0] a_owner, b_owner, c_owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbiter_rr_param #(.NUM_PORTS(5), .IDLE_FIRST(4), .HOLD_MAX(0)) u_dut_a (
        .clk(clk), .rst(rst), .req(a_req), .dcts(a_dcts), .rts(a_rts),
        .grant(a_grant), .xbar_sel(a_xbar), .owner(a_owner), .busy(a_busy));

    arbiter_rr_param #(.NUM_PORTS(5), .IDLE_FIRST(4), .HOLD_MAX(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(b_req), .dcts(b_dcts), .rts(b_rts),
        .grant(b_grant), .xbar_sel(b_xbar), .owner(b_owner), .busy(b_busy));

    arbiter_rr_param #(.NUM_PORTS(8), .IDLE_FIRST(7), .HOLD_MAX(0)) u_dut_c (
        .clk(clk), .rst(rst), .req(c_req), .dcts(c_dcts), .rts(c_rts),
        .grant(c_grant), .xbar_sel(c_xbar), .owner(c_owner), .busy(c_busy));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [4:0] exp_b [10] = '{5'h00, 5'h01, 5'h00, 5'h01, 5'h00,
                               5'h02, 5'h00, 5'h02, 5'h00, 5'h01};

    initial begin
        // Reset with every requester active.
        rst = 1'b1; a_req = 5'h1f; a_dcts = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_rts",   32'(a_rts),   32'h0);
            check_val("rst_grant", 32'(a_grant), 32'h0);
            check_val("rst_xbar",  32'(a_xbar),  32'h0);
            check_val("rst_busy",  32'(a_busy),  32'h0);
            check_val("rst_owner", 32'(a_owner), 32'h0);
        end

        // IDLE -> Local first; no grant in the cycle the owner is taken.
        a_req = 5'b10001; a_dcts = 1'b1;
        @(negedge clk); rst = 1'b0;
        step();
        check_val("t2_xbar",  32'(a_xbar),  32'h10);
        check_val("t2_owner", 32'(a_owner), 32'h4);
        check_val("t2_busy",  32'(a_busy),  32'h1);
        check_val("t2_rts0",  32'(a_rts),   32'h0);
        check_val("t2_gnt0",  32'(a_grant), 32'h0);
        step();
        check_val("t2_rts1",  32'(a_rts),   32'h1);
        check_val("t2_gnt1",  32'(a_grant), 32'h10);
        step();
        check_val("t2_rtsdrop", 32'(a_rts),  32'h0);
        check_val("t2_keep",    32'(a_xbar), 32'h10);

        // Move to OWN(1), then stall with dcts low.
        a_req = 5'b00010; a_dcts = 1'b0;
        step();
        check_val("t3_owner", 32'(a_owner), 32'h1);
        check_val("t3_rts",   32'(a_rts),   32'h1);
        a_req = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t3_stall_rts",   32'(a_rts),   32'h1);
            check_val("t3_stall_owner", 32'(a_owner), 32'h1);
            check_val("t3_stall_gnt",   32'(a_grant), 32'h0);
        end
        a_dcts = 1'b1; #1;
        check_val("t3_release_gnt", 32'(a_grant), 32'h02);
        step();
        check_val("t3_idle_busy", 32'(a_busy),  32'h0);
        check_val("t3_idle_xbar", 32'(a_xbar),  32'h0);
        check_val("t3_idle_own",  32'(a_owner), 32'h0);

        // OWN(2) drops while 0 and 1 request: search 3,4,0 lands on 0.
        a_req = 5'b00100;
        step();
        check_val("t4_owner2", 32'(a_owner), 32'h2);
        step();
        check_val("t4_gnt2", 32'(a_grant), 32'h04);
        a_req = 5'b00011;
        step();
        check_val("t4_xbar0",  32'(a_xbar),  32'h01);
        check_val("t4_owner0", 32'(a_owner), 32'h0);

        // Reset in the middle of ownership aborts it.
        rst = 1'b1;
        step();
        check_val("t4_rst_rts",  32'(a_rts),  32'h0);
        check_val("t4_rst_busy", 32'(a_busy), 32'h0);
        rst = 1'b0;

        // Hold limit 2: two grants per owner, alternating 0 and 1.
        b_req = 5'b00011; b_dcts = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val($sformatf("t5_gnt_c%0d", i + 1), 32'(b_grant), 32'(exp_b[i]));
        end

        // 8-port build: start at 7, wrap to 0 once 7 drops.
        c_req = 8'h81; c_dcts = 1'b1;
        step();
        check_val("t6_owner7", 32'(c_owner), 32'h7);
        check_val("t6_xbar7",  32'(c_xbar),  32'h80);
        step();
        check_val("t6_gnt7", 32'(c_grant), 32'h80);
        c_req = 8'h01;
        step();
        check_val("t6_owner0", 32'(c_owner), 32'h0);
        check_val("t6_xbar0",  32'(c_xbar),  32'h01);
        check_val("t6_busy",   32'(c_busy),  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
